// File: rtl/stream_src_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_src_pkg
//  Description : Shared types and constants for the LFSR stream source.
//  Revision    : 1.0  initial release
// ============================================================================
package stream_src_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Galois feedback mask for taps 32,22,2,1
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    function automatic logic [31:0] seed_of(input logic [31:0] base, input int unsigned k);
        return base + 32'(k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_source_if
//  Description : Run control plus per-lane ap_fifo read-side stream bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface stream_fifo_source_if #(
    parameter int N_LANES = 8,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16
);
    logic                        start;
    logic [LEN_W-1:0]            len;
    logic                        busy;
    logic                        done;
    logic [N_LANES*DATA_W-1:0]   D_in_dout;
    logic [N_LANES-1:0]          D_in_empty_n;
    logic [N_LANES-1:0]          D_in_read;

    // master: controller/kernel side; slave: the stream source
    modport master (
        output start, len, D_in_read,
        input  busy, done, D_in_dout, D_in_empty_n
    );

    modport slave (
        input  start, len, D_in_read,
        output busy, done, D_in_dout, D_in_empty_n
    );
endinterface
`default_nettype wire

// File: rtl/stream_src_lane.sv
`default_nettype none
// ============================================================================
//  Module      : stream_src_lane
//  Description : One stream lane: LFSR data, remaining word count, empty_n.
//  Revision    : 1.0  initial release
// ============================================================================
module stream_src_lane
    import stream_src_pkg::*;
#(
    parameter int                 DATA_W = 32,
    parameter int                 LEN_W  = 16,
    parameter logic [DATA_W-1:0]  SEED   = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [LEN_W-1:0]  i_len,
    input  wire logic              i_rd,
    output logic      [DATA_W-1:0] o_dout,
    output logic                   o_empty_n,
    output logic                   o_drained
);

    localparam logic [DATA_W-1:0] c_poly = DATA_W'(LFSR_POLY);

    logic [DATA_W-1:0] lfsr_q,    lfsr_d;
    logic [LEN_W-1:0]  count_q,   count_d;
    logic              empty_n_q, empty_n_d;

    always_comb begin
        lfsr_d    = lfsr_q;
        count_d   = count_q;
        empty_n_d = empty_n_q;
        if (i_load) begin
            lfsr_d    = SEED;
            count_d   = i_len;
            empty_n_d = (i_len != '0);
        end else if (i_rd && empty_n_q) begin
            lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? c_poly : '0);
            count_d   = count_q - LEN_W'(1);
            empty_n_d = (count_q != LEN_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q    <= SEED;
            count_q   <= '0;
            empty_n_q <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
        end
    end

    // Looks at the next count so the run can close on the final-read edge
    assign o_drained = (count_d == '0);
    assign o_dout    = lfsr_q;
    assign o_empty_n = empty_n_q;

endmodule
`default_nettype wire

// File: rtl/stream_fifo_source.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_source
//  Description : LFSR-backed ap_fifo stimulus source for N kernel input lanes.
//  Revision    : 1.0  initial release
// ============================================================================
module stream_fifo_source
    import stream_src_pkg::*;
#(
    parameter int          N_LANES   = 8,
    parameter int          DATA_W    = 32,
    parameter int          LEN_W     = 16,
    parameter logic [31:0] SEED_BASE = 32'h00000001
) (
    input  wire logic            ap_clk,
    input  wire logic            ap_rst,
    stream_fifo_source_if.slave  bus
);

    state_t state_q;
    logic   busy_q;
    logic   done_q;

    logic                      w_load;
    logic [N_LANES-1:0]        w_drained;
    logic [N_LANES-1:0]        w_empty_n;
    logic [N_LANES*DATA_W-1:0] w_dout;

    // Only an idle source accepts a run; len is captured by the lanes here
    assign w_load = (state_q == IDLE) && bus.start && (bus.len != '0);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lanes
        stream_src_lane #(
            .DATA_W (DATA_W),
            .LEN_W  (LEN_W),
            .SEED   (DATA_W'(seed_of(SEED_BASE, i)))
        ) u_lane (
            .clk       (ap_clk),
            .rst       (ap_rst),
            .i_load    (w_load),
            .i_len     (bus.len),
            .i_rd      (bus.D_in_read[i]),
            .o_dout    (w_dout[i*DATA_W +: DATA_W]),
            .o_empty_n (w_empty_n[i]),
            .o_drained (w_drained[i])
        );
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (&w_drained) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.D_in_dout    = w_dout;
    assign bus.D_in_empty_n = w_empty_n;

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_fifo_source
//  Description : Scoreboard bench for the LFSR stream source.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stream_fifo_source;

    localparam int          N  = 8;
    localparam int          DW = 32;
    localparam int          LW = 16;
    localparam logic [31:0] SB = 32'h00000001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_fifo_source_if #(.N_LANES(N), .DATA_W(DW), .LEN_W(LW)) bus ();

    stream_fifo_source #(
        .N_LANES(N), .DATA_W(DW), .LEN_W(LW), .SEED_BASE(SB)
    ) dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus)
    );

    int n_err = 0;
    int n_chk = 0;
    int ncyc  = 0;
    always @(posedge clk) ncyc++;

    typedef logic [31:0] word_q_t[$];
    word_q_t exp_q[N];

    int         rd_cnt[N];
    int         first_cyc[N];
    int         last_cyc[N];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         s_cyc    = 0;
    logic [N-1:0] empty_or;
    logic [N-1:0] rd_mask = '0;
    logic [N-1:0] spur    = '0;
    int           slow_lane = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Scoreboard consumer: a word is taken whenever empty_n and read are both high
    always @(negedge clk) begin
        if (!rst) begin
            empty_or = empty_or | bus.D_in_empty_n;
            for (int k = 0; k < N; k++) begin
                if (bus.D_in_empty_n[k] && bus.D_in_read[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("lane%0d_extra_word", k), 1, 0);
                    end else begin
                        check($sformatf("lane%0d_data", k), bus.D_in_dout[k*DW +: DW], exp_q[k].pop_front());
                    end
                    rd_cnt[k]++;
                    if (rd_cnt[k] == 1) first_cyc[k] = ncyc;
                    last_cyc[k] = ncyc;
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = ncyc;
                check("busy_low_with_done", bus.busy, 0);
            end
        end
    end

    task automatic cycle();
        logic [N-1:0] r;
        @(posedge clk);
        #1;
        r = rd_mask | spur;
        if (slow_lane >= 0) r[slow_lane] = ((ncyc % 5) == 0);
        bus.D_in_read = r;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < N; k++) begin
            rd_cnt[k] = 0; first_cyc[k] = 0; last_cyc[k] = 0;
        end
        empty_or = '0;
    endtask

    task automatic push_run(input int l);
        logic [31:0] x;
        for (int k = 0; k < N; k++) begin
            x = SB + 32'(k);
            for (int j = 0; j < l; j++) begin
                exp_q[k].push_back(x);
                x = lfsr_next(x);
            end
        end
    endtask

    task automatic do_start(input int l, input bit accepted);
        bus.start = 1'b1;
        bus.len   = LW'(l);
        if (accepted) push_run(l);
        s_cyc = ncyc;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int base;
        base = done_cnt;
        for (int i = 0; i < max_cyc && done_cnt == base; i++) cycle();
        check("done_seen", (done_cnt != base), 1);
    endtask

    task automatic finish_run(input int l, input int done_base);
        int mx;
        repeat (4) cycle();
        mx = 0;
        for (int k = 0; k < N; k++) begin
            check($sformatf("lane%0d_words", k), rd_cnt[k], l);
            check($sformatf("lane%0d_sb_left", k), exp_q[k].size(), 0);
            if (last_cyc[k] > mx) mx = last_cyc[k];
        end
        check("done_once", done_cnt - done_base, 1);
        check("done_after_last_read", done_cyc, mx + 1);
        @(negedge clk);
        check("busy_after_run", bus.busy, 0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.len = '0;
        bus.D_in_read = '0;
        for (int k = 0; k < N; k++) exp_q[k].delete();
        clear_stats();

        // Reset state
        repeat (4) cycle();
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_empty_n", bus.D_in_empty_n, 8'h00);
        check("rst_dout0", bus.D_in_dout[0 +: DW], 32'h00000001);
        check("rst_dout1", bus.D_in_dout[DW +: DW], 32'h00000002);
        cycle();
        rst = 1'b0;
        cycle();

        // Basic run: lane 0 drained first, others later
        clear_stats();
        base = done_cnt;
        rd_mask = 8'h01;
        do_start(3, 1'b1);
        @(negedge clk);
        check("run_busy", bus.busy, 1);
        check("run_empty_n", bus.D_in_empty_n, 8'hFF);
        check("basic_w0", bus.D_in_dout[0 +: DW], 32'h00000001);
        cycle(); @(negedge clk);
        check("basic_w1", bus.D_in_dout[0 +: DW], 32'h80200003);
        cycle(); @(negedge clk);
        check("basic_w2", bus.D_in_dout[0 +: DW], 32'hC0300002);
        cycle(); @(negedge clk);
        check("basic_lane0_empty", bus.D_in_empty_n[0], 0);
        check("basic_no_early_done", done_cnt - base, 0);
        check("basic_still_busy", bus.busy, 1);
        rd_mask = 8'hFF;
        wait_done(50);
        finish_run(3, base);

        // All lanes, continuous reads
        rd_mask = '0; cycle();
        clear_stats();
        base = done_cnt;
        rd_mask = 8'hFF;
        do_start(4, 1'b1);
        wait_done(50);
        finish_run(4, base);
        for (int k = 0; k < N; k++) check($sformatf("lane%0d_no_bubble", k), last_cyc[k] - first_cyc[k], 3);

        // Uneven drain, spurious read on lane 5 while it is still empty
        rd_mask = '0; spur = 8'h20; cycle(); spur = '0;
        clear_stats();
        base = done_cnt;
        @(negedge clk);
        check("spur_lane5_empty", bus.D_in_empty_n[5], 0);
        rd_mask = 8'hF7; slow_lane = 3;
        do_start(2, 1'b1);
        wait_done(80);
        finish_run(2, base);
        check("slow_lane_gates_done", done_cyc, last_cyc[3] + 1);
        slow_lane = -1;

        // len = 0: done next cycle, no data
        rd_mask = '0; cycle();
        clear_stats();
        base = done_cnt;
        do_start(0, 1'b0);
        wait_done(10);
        repeat (3) cycle();
        check("len0_done_cycle", done_cyc, s_cyc + 1);
        check("len0_no_empty_n", empty_or, 0);
        check("len0_done_once", done_cnt - base, 1);

        // Start while busy is ignored
        clear_stats();
        base = done_cnt;
        do_start(2, 1'b1);
        do_start(7, 1'b0);
        rd_mask = 8'hFF;
        wait_done(50);
        finish_run(2, base);

        // Reset mid-run, then restart
        rd_mask = '0; cycle();
        clear_stats();
        rd_mask = 8'hFF;
        do_start(5, 1'b1);
        rd_mask = '0;
        cycle();
        rst = 1'b1;
        base = done_cnt;
        for (int k = 0; k < N; k++) exp_q[k].delete();
        cycle(); cycle();
        @(negedge clk);
        check("midrst_lane0_words", rd_cnt[0], 1);
        check("midrst_empty_n", bus.D_in_empty_n, 8'h00);
        check("midrst_busy", bus.busy, 0);
        check("midrst_dout0", bus.D_in_dout[0 +: DW], 32'h00000001);
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        check("midrst_no_done", done_cnt - base, 0);
        clear_stats();
        rd_mask = 8'hFF;
        do_start(2, 1'b1);
        wait_done(50);
        finish_run(2, base);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
